// File: rtl/selector14_pkg.sv
// Shared constants and helpers for the selector14/selector41 link blocks.
package selector14_pkg;

    localparam int CHAN_N = 4;  // channels carried on the link
    localparam int CHAN_W = 2;  // bits needed to name a channel

    // Decode a channel number into its one-hot channel mask.
    function automatic logic [CHAN_N-1:0] onehot4(input logic [CHAN_W-1:0] sel);
        onehot4      = '0;
        onehot4[sel] = 1'b1;
    endfunction

endpackage

// File: rtl/selector14_ctrl.sv
// Channel steering for the 1-to-4 distributor: picks the target channel,
// owns the round-robin counter and frame mask, and produces the write
// enables, strobe and frame pulse.
module selector14_ctrl
    import selector14_pkg::*;
(
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iValid,
    input  logic              iS1,
    input  logic              iS0,
    input  logic              iAuto,
    input  logic              iClear,
    output logic [CHAN_N-1:0] wrEn,
    output logic [CHAN_N-1:0] oStrobe,
    output logic              oFrame,
    output logic [CHAN_W-1:0] oChan
);

    logic [CHAN_W-1:0] count;
    logic [CHAN_W-1:0] tgt;
    logic [CHAN_N-1:0] mask;
    logic [CHAN_N-1:0] nextMask;

    // Target channel and write enables for the current cycle.
    // NOTE: every signal driven here is assigned on every path, so no latch is inferred.
    always_comb begin
        tgt      = iAuto ? count : {iS1, iS0};
        wrEn     = iValid ? onehot4(tgt) : '0;
        nextMask = mask | wrEn;
    end

    // Counter, frame mask, strobe and frame pulse registers.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            count   <= '0;
            mask    <= '0;
            oStrobe <= '0;
            oFrame  <= 1'b0;
        end else begin
            // The strobe reports the write even when a clear lands in the same cycle.
            oStrobe <= wrEn;
            if (iClear) begin
                // A write alongside a clear is not credited to any frame.
                count  <= '0;
                mask   <= '0;
                oFrame <= 1'b0;
            end else if (iValid) begin
                if (iAuto) begin
                    count <= count + 1'b1;  // wraps 3 -> 0
                end
                if (nextMask == '1) begin
                    oFrame <= 1'b1;
                    mask   <= '0;
                end else begin
                    oFrame <= 1'b0;
                    mask   <= nextMask;
                end
            end else begin
                oFrame <= 1'b0;
            end
        end
    end

    assign oChan = count;

endmodule

// File: rtl/selector14_reg.sv
// Registered 1-to-4 distributor: steers each valid input word into one of
// four holding registers chosen by manual select or round-robin counter.
module selector14_reg
    import selector14_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic [WIDTH-1:0]  iD,
    input  logic              iValid,
    input  logic              iS1,
    input  logic              iS0,
    input  logic              iAuto,
    input  logic              iClear,
    output logic [WIDTH-1:0]  oY0,
    output logic [WIDTH-1:0]  oY1,
    output logic [WIDTH-1:0]  oY2,
    output logic [WIDTH-1:0]  oY3,
    output logic [CHAN_N-1:0] oStrobe,
    output logic              oFrame,
    output logic [CHAN_W-1:0] oChan
);

    logic [CHAN_N-1:0] wrEn;
    logic [WIDTH-1:0]  yReg [CHAN_N];

    selector14_ctrl uCtrl (
        .iClk    (iClk),
        .iRst    (iRst),
        .iValid  (iValid),
        .iS1     (iS1),
        .iS0     (iS0),
        .iAuto   (iAuto),
        .iClear  (iClear),
        .wrEn    (wrEn),
        .oStrobe (oStrobe),
        .oFrame  (oFrame),
        .oChan   (oChan)
    );

    // Holding registers: each loads iD when its channel is written, else holds.
    // NOTE: the holding registers are reset because downstream reads them as zero after reset.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            for (int k = 0; k < CHAN_N; k++) begin
                yReg[k] <= '0;
            end
        end else begin
            for (int k = 0; k < CHAN_N; k++) begin
                if (wrEn[k]) begin
                    yReg[k] <= iD;
                end
            end
        end
    end

    assign oY0 = yReg[0];
    assign oY1 = yReg[1];
    assign oY2 = yReg[2];
    assign oY3 = yReg[3];

endmodule
